multi_port_user_csr: RTL

MULTI_PORT_USER_CSR -- requirements
Module: multi_port_user_csr

---
 rtl/multi_port_csr_pkg.sv | 25 ++
 rtl/csr_rst_handshake.sv | 71 +++++++
 rtl/multi_port_user_csr.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/multi_port_csr_pkg.sv
// Shared constants, register map and handshake state type
// for the multi-port user CSR block.
package multi_port_csr_pkg;

    localparam logic [31:0] VERSION      = 32'h0001_0100;

    localparam logic [11:0] ADDR_VERSION = 12'h000;
    localparam logic [11:0] ADDR_GLOBAL  = 12'h004;
    localparam logic [11:0] PORT_BASE    = 12'h100;
    localparam logic [11:0] PORT_STRIDE  = 12'h020;

    localparam logic [4:0] OFF_CONTROL  = 5'h00;
    localparam logic [4:0] OFF_STATUS   = 5'h04;
    localparam logic [4:0] OFF_STICKY   = 5'h08;
    localparam logic [4:0] OFF_FIFO     = 5'h0C;
    localparam logic [4:0] OFF_IRQ_MASK = 5'h10;
    localparam logic [4:0] OFF_ERROR    = 5'h14;

    typedef enum logic [1:0] {
        HS_IDLE    = 2'd0,
        HS_ASSERT  = 2'd1,
        HS_RELEASE = 2'd2
    } hs_state_t;

endpackage

// File: rtl/csr_rst_handshake.sv
// One reset-request/acknowledge handshake with timeout,
// for a single reset domain of a single port.
module csr_rst_handshake
    import multi_port_csr_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic ack,
    output logic rst_n,
    output logic busy,
    output logic timeout
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    hs_state_t     state;
    hs_state_t     state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_hit;

    assign cnt_hit = (cnt == CW'(ACK_TIMEOUT - 1));
    assign busy    = (state != HS_IDLE);

    always_comb begin
        state_nxt = state;
        timeout   = 1'b0;
        unique case (state)
            HS_IDLE: begin
                if (start) state_nxt = HS_ASSERT;
            end
            HS_ASSERT: begin
                if (!ack) begin
                    state_nxt = HS_RELEASE;
                end else if (cnt_hit) begin
                    state_nxt = HS_IDLE;
                    timeout   = 1'b1;
                end
            end
            HS_RELEASE: begin
                if (ack) begin
                    state_nxt = HS_IDLE;
                end else if (cnt_hit) begin
                    state_nxt = HS_IDLE;
                    timeout   = 1'b1;
                end
            end
            default: state_nxt = HS_IDLE;
        endcase
    end

    // rst_n is registered from the next state so it is glitch-free
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= HS_IDLE;
            cnt   <= '0;
            rst_n <= 1'b1;
        end else begin
            state <= state_nxt;
            if (state_nxt != state || state == HS_IDLE) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            rst_n <= (state_nxt != HS_ASSERT);
        end
    end

endmodule

// File: rtl/multi_port_user_csr.sv
// CSR block for up to four Ethernet ports: MAC reset handshakes,
// live and sticky PHY status, FIFO levels and a level interrupt.
module multi_port_user_csr
    import multi_port_csr_pkg::*;
#(
    parameter int NUM_CHANNELS = 2,
    parameter int FIFO_DEPTH   = 5,
    parameter int ACK_TIMEOUT  = 1023
) (
    input  logic                               csr_clk,
    input  logic                               reset,
    input  logic [11:0]                        csr_address,
    input  logic                               csr_read,
    input  logic                               csr_write,
    input  logic [3:0]                         csr_byteenable,
    input  logic [31:0]                        csr_wr_data,
    output logic                               csr_waitrequest,
    output logic [31:0]                        csr_rd_data,
    output logic                               csr_rd_vld,
    input  logic [NUM_CHANNELS-1:0]            ack_i_rst_n,
    input  logic [NUM_CHANNELS-1:0]            ack_i_tx_rst_n,
    input  logic [NUM_CHANNELS-1:0]            ack_i_rx_rst_n,
    output logic [NUM_CHANNELS-1:0]            o_rst_n,
    output logic [NUM_CHANNELS-1:0]            o_tx_rst_n,
    output logic [NUM_CHANNELS-1:0]            o_rx_rst_n,
    input  logic [NUM_CHANNELS-1:0]            i_rx_pcs_ready,
    input  logic [NUM_CHANNELS-1:0]            i_tx_lanes_stable,
    input  logic [NUM_CHANNELS-1:0]            i_tx_pll_locked,
    input  logic [NUM_CHANNELS-1:0]            i_cdr_lock,
    input  logic                               i_sys_pll_locked,
    input  logic [NUM_CHANNELS*FIFO_DEPTH-1:0] i_tx_fifo_depth,
    input  logic [NUM_CHANNELS*FIFO_DEPTH-1:0] i_rx_fifo_depth,
    output logic                               o_irq
);

    localparam int N  = NUM_CHANNELS;
    localparam int NA = 7 * N + 1;

    logic [NA-1:0] meta;
    logic [NA-1:0] sync;

    always_ff @(posedge csr_clk) begin
        if (reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= {i_sys_pll_locked, i_cdr_lock, i_tx_pll_locked,
                     i_tx_lanes_stable, i_rx_pcs_ready,
                     ack_i_rx_rst_n, ack_i_tx_rst_n, ack_i_rst_n};
            sync <= meta;
        end
    end

    logic [N-1:0] ack_rst_s, ack_tx_s, ack_rx_s;
    logic [N-1:0] rx_pcs_s, tx_lanes_s, tx_pll_s, cdr_s;
    logic         sys_pll_s;

    assign ack_rst_s  = sync[0*N +: N];
    assign ack_tx_s   = sync[1*N +: N];
    assign ack_rx_s   = sync[2*N +: N];
    assign rx_pcs_s   = sync[3*N +: N];
    assign tx_lanes_s = sync[4*N +: N];
    assign tx_pll_s   = sync[5*N +: N];
    assign cdr_s      = sync[6*N +: N];
    assign sys_pll_s  = sync[7*N];

    logic wr_acc;
    logic rd_acc;

    assign wr_acc = csr_write & ~csr_waitrequest;
    assign rd_acc = csr_read & ~csr_waitrequest;

    always_ff @(posedge csr_clk) begin
        if (reset) begin
            csr_waitrequest <= 1'b1;
        end else if (csr_waitrequest && (csr_read || csr_write)) begin
            csr_waitrequest <= 1'b0;
        end else begin
            csr_waitrequest <= 1'b1;
        end
    end

    logic [4:0]   off;
    logic [31:0]  port_rd [N];
    logic [N-1:0] port_hit;
    logic [N-1:0] irq_vec;
    logic [N-1:0] err_vec;

    assign off = csr_address[4:0];

    for (genvar p = 0; p < N; p++) begin : g_port
        logic       hit;
        logic       wr0;
        logic [2:0] start, busy, tmo, ack_s, rst_n;
        logic [3:0] status, prev, sticky, sticky_clr;
        logic [2:0] err, err_clr;
        logic [4:0] mask;
        logic [31:0] rd;

        assign hit = ({csr_address[11:5], 5'b0} ==
                      12'(PORT_BASE + PORT_STRIDE * p));
        assign wr0 = wr_acc & hit & csr_byteenable[0];

        assign start = (wr0 && off == OFF_CONTROL) ?
                       csr_wr_data[2:0] : 3'b000;
        assign sticky_clr = (wr0 && off == OFF_STICKY) ?
                            csr_wr_data[3:0] : 4'b0000;
        assign err_clr = (wr0 && off == OFF_ERROR) ?
                         csr_wr_data[2:0] : 3'b000;

        assign ack_s = {ack_rx_s[p], ack_tx_s[p], ack_rst_s[p]};

        for (genvar d = 0; d < 3; d++) begin : g_hs
            csr_rst_handshake #(
                .ACK_TIMEOUT(ACK_TIMEOUT)
            ) u_hs (
                .clk    (csr_clk),
                .reset  (reset),
                .start  (start[d]),
                .ack    (ack_s[d]),
                .rst_n  (rst_n[d]),
                .busy   (busy[d]),
                .timeout(tmo[d])
            );
        end

        assign o_rst_n[p]    = rst_n[0];
        assign o_tx_rst_n[p] = rst_n[1];
        assign o_rx_rst_n[p] = rst_n[2];

        assign status = {cdr_s[p], tx_pll_s[p], tx_lanes_s[p], rx_pcs_s[p]};

        // new events are OR-ed in after the clear so a set wins
        always_ff @(posedge csr_clk) begin
            if (reset) begin
                prev   <= '0;
                sticky <= '0;
                err    <= '0;
                mask   <= '0;
            end else begin
                prev   <= status;
                sticky <= (sticky & ~sticky_clr) | (prev & ~status);
                err    <= (err & ~err_clr) | tmo;
                if (wr0 && off == OFF_IRQ_MASK) begin
                    mask <= csr_wr_data[4:0];
                end
            end
        end

        always_comb begin
            rd = '0;
            case (off)
                OFF_CONTROL:  rd[2:0] = busy;
                OFF_STATUS:   rd[3:0] = status;
                OFF_STICKY:   rd[3:0] = sticky;
                OFF_FIFO: begin
                    rd[FIFO_DEPTH-1:0] =
                        i_tx_fifo_depth[p*FIFO_DEPTH +: FIFO_DEPTH];
                    rd[16 +: FIFO_DEPTH] =
                        i_rx_fifo_depth[p*FIFO_DEPTH +: FIFO_DEPTH];
                end
                OFF_IRQ_MASK: rd[4:0] = mask;
                OFF_ERROR:    rd[2:0] = err;
                default:      rd = '0;
            endcase
        end

        assign port_rd[p]  = rd;
        assign port_hit[p] = hit;
        assign err_vec[p]  = |err;
        assign irq_vec[p]  = (|(sticky & mask[3:0])) | ((|err) & mask[4]);
    end

    logic [31:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        unique case (1'b1)
            (csr_address == ADDR_VERSION): rd_mux = VERSION;
            (csr_address == ADDR_GLOBAL):  rd_mux = {30'b0, |err_vec, sys_pll_s};
            (|port_hit): begin
                for (int p = 0; p < N; p++) begin
                    if (port_hit[p]) rd_mux = port_rd[p];
                end
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge csr_clk) begin
        if (reset) begin
            csr_rd_vld  <= 1'b0;
            csr_rd_data <= '0;
            o_irq       <= 1'b0;
        end else begin
            csr_rd_vld <= rd_acc;
            if (rd_acc) csr_rd_data <= rd_mux;
            o_irq <= |irq_vec;
        end
    end

    // every field lives in byte 0
    logic unused;
    assign unused = ^{csr_byteenable[3:1], csr_wr_data[31:5]};

endmodule
